// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: queue entry,
// fetch FSM states, the NOP used for trap entries and a count-width helper.
package fetch_pkg;

    localparam int unsigned DEFAULT_QUEUE_DEPTH = 2;
    localparam logic [31:0] NOP_INST            = 32'h0000_0013;
    localparam logic [31:0] PC_STEP             = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    // Width able to hold the values 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush, used both as the decode-facing fetch queue
// and as the pc tracker for in-flight memory requests.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter type          T     = fetch_entry_t,
    localparam int unsigned CW    = count_width(DEPTH),
    localparam int unsigned PW    = CW - 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointer/occupancy update; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
            count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = (count_q != '0);
    assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order imem requests, queues returned words with their pc
// for decode, steers the pc. Optional misaligned-pc trap under FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_write_enable,
    output logic [31:0] next_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam int unsigned CNT_W  = count_width(QUEUE_DEPTH);
    // Extra headroom: back-to-back redirects can stack stale responses still in memory.
    localparam int unsigned DROP_W = CNT_W + 3;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    fetch_state_t      state_q, state_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              fault_latch_q, fault_latch_d;

    logic [CNT_W-1:0]  credits_s;
    logic              misalign_s;
    logic              resp_take_s;
    logic              resp_drop_s;
    logic              req_valid_s;
    logic              pc_we_s;
    logic [31:0]       next_pc_s;
    logic              q_push_s;
    logic              q_flush_s;
    fetch_entry_t      q_entry_s;
    fetch_entry_t      q_head_s;
    logic              q_head_valid_s;
    logic [CNT_W-1:0]  q_count_s;
    logic              trk_push_s;
    logic              trk_pop_s;
    logic [31:0]       trk_head_s;
    logic              trk_head_valid_s;
    logic [CNT_W-1:0]  trk_count_s;

    // The tracker occupancy is the number of requests awaiting a kept response.
    assign credits_s   = CNT_W'(QUEUE_DEPTH) - q_count_s - trk_count_s;
    assign misalign_s  = TRAP_EN && (pc[1:0] != 2'b00);
    assign resp_drop_s = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_take_s = imem_resp_valid && (drop_cnt_q == '0) && trk_head_valid_s;

    // FSM next state, issue, response routing and redirect flush.
    always_comb begin
        state_d       = state_q;
        drop_cnt_d    = drop_cnt_q;
        fault_latch_d = fault_latch_q;
        req_valid_s   = 1'b0;
        pc_we_s       = 1'b0;
        next_pc_s     = 32'h0000_0000;
        q_push_s      = 1'b0;
        q_flush_s     = 1'b0;
        q_entry_s     = '0;
        trk_push_s    = 1'b0;
        trk_pop_s     = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH, HOLD: begin
                next_pc_s = pc + PC_STEP;
                if (redirect_valid) begin
                    pc_we_s       = 1'b1;
                    next_pc_s     = redirect_pc;
                    q_flush_s     = 1'b1;
                    // Everything still owed by memory after this cycle becomes stale.
                    drop_cnt_d    = drop_cnt_q - DROP_W'(resp_drop_s) + DROP_W'(trk_count_s)
                                  - DROP_W'(resp_take_s);
                    fault_latch_d = 1'b0;
                    state_d       = FETCH;
                end else begin
                    drop_cnt_d = resp_drop_s ? (drop_cnt_q - DROP_W'(1)) : drop_cnt_q;
                    if (resp_take_s) begin
                        q_push_s  = 1'b1;
                        q_entry_s = '{pc: trk_head_s, inst: imem_resp_data, fault: 1'b0};
                        trk_pop_s = 1'b1;
                    end else begin
                        trk_pop_s = 1'b0;
                    end
                    if ((state_q == FETCH) && (credits_s != '0) && !fault_latch_q) begin
                        if (misalign_s) begin
                            // Wait for older fetches to land so the fault entry stays in order.
                            if (trk_count_s == '0) begin
                                q_push_s      = 1'b1;
                                q_entry_s     = '{pc: pc, inst: NOP_INST, fault: 1'b1};
                                fault_latch_d = 1'b1;
                            end else begin
                                fault_latch_d = fault_latch_q;
                            end
                        end else begin
                            req_valid_s = 1'b1;
                            pc_we_s     = imem_req_ready;
                            trk_push_s  = imem_req_ready;
                        end
                    end else begin
                        req_valid_s = 1'b0;
                    end
                    if (state_q == FETCH) begin
                        state_d = ((credits_s == '0) || fault_latch_q) ? HOLD : FETCH;
                    end else begin
                        state_d = ((credits_s != '0) && !fault_latch_q) ? FETCH : HOLD;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            drop_cnt_q    <= '0;
            fault_latch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drop_cnt_q    <= drop_cnt_d;
            fault_latch_q <= fault_latch_d;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .T(fetch_entry_t)) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (q_flush_s),
        .push       (q_push_s),
        .push_data  (q_entry_s),
        .pop        (inst_ready),
        .head       (q_head_s),
        .head_valid (q_head_valid_s),
        .count      (q_count_s)
    );

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .T(logic [31:0])) u_pc_tracker (
        .clock      (clock),
        .reset      (reset),
        .flush      (q_flush_s),
        .push       (trk_push_s),
        .push_data  (pc),
        .pop        (trk_pop_s),
        .head       (trk_head_s),
        .head_valid (trk_head_valid_s),
        .count      (trk_count_s)
    );

    assign pc_write_enable = pc_we_s;
    assign next_pc         = next_pc_s;
    assign imem_req_valid  = req_valid_s;
    assign imem_req_addr   = {pc[31:2], 2'b00};
    assign inst_valid      = q_head_valid_s;
    assign inst_data       = q_head_s.inst;
    assign inst_pc         = q_head_s.pc;
    assign inst_fault      = q_head_s.fault & TRAP_EN;

endmodule
